pipe_hazard_unit: RTL and testbench

Parametrised hazard and forwarding unit for the pipelined MIPS core. It sits beside the decode stage and keeps a scoreboard shift register of the destination registers in flight in the downstream stages. Each cycle it selects forwarded operand data, raises a load-use stall and applies branch flushes. This removes the need for NOP padding in test programs.

---
 rtl/pipe_hazard_unit.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Hazard and forwarding unit for the pipelined MIPS core. It
//               keeps a shift-register scoreboard of the destination
//               registers of the instructions in flight after decode. From
//               that scoreboard it selects forwarded operands for the decode
//               instruction, raises a one-cycle load-use stall, and applies
//               branch flushes.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               id_*                 - decode-stage instruction fields
//               ex_branch_taken      - branch resolved taken in EX
//               rf_rs/rt_data        - register-file read data
//               res_data             - per-stage results, stage k in
//                                      slice [k*XLEN +: XLEN]
//               fwd_rs/rt_data/sel   - resolved operands and their source
//                                      (0 = register file, k+1 = stage k)
//               stall, flush         - pipeline control
//               stall_cnt, flush_cnt - event counters, present only when
//                                      HAZARD_PERF_EN is defined
// Options     : HAZARD_PERF_EN adds saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rs,
    input  logic [REG_AW-1:0]       id_rt,
    input  logic                    id_use_rs,
    input  logic                    id_use_rt,
    input  logic [REG_AW-1:0]       id_dst,
    input  logic                    id_we,
    input  logic                    id_is_load,
    input  logic                    ex_branch_taken,
    input  logic [XLEN-1:0]         rf_rs_data,
    input  logic [XLEN-1:0]         rf_rt_data,
    input  logic [DEPTH*XLEN-1:0]   res_data,
    output logic [XLEN-1:0]         fwd_rs_data,
    output logic [XLEN-1:0]         fwd_rt_data,
    output logic [SEL_W-1:0]        fwd_rs_sel,
    output logic [SEL_W-1:0]        fwd_rt_sel,
    output logic                    stall,
    output logic                    flush
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             flush_cnt
`endif
);

    // Scoreboard: entry k describes the instruction currently in stage k.
    logic [DEPTH-1:0]             sb_valid_q;
    logic [DEPTH-1:0]             sb_we_q;
    logic [DEPTH-1:0]             sb_load_q;
    logic [DEPTH-1:0][REG_AW-1:0] sb_dst_q;

    logic w_entry0_valid_d;
    logic w_rs_load0;
    logic w_rt_load0;

    // Forwarding selection. Scanning from the oldest stage down to the
    // youngest lets the lowest matching k overwrite older matches, so the
    // most recent producer wins. A source of r0 never matches, which also
    // covers the "dst != 0" condition since dst must equal the source.
    always_comb begin
        fwd_rs_sel  = '0;
        fwd_rs_data = rf_rs_data;
        w_rs_load0  = 1'b0;
        fwd_rt_sel  = '0;
        fwd_rt_data = rf_rt_data;
        w_rt_load0  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (id_use_rs && (id_rs != '0) && sb_valid_q[k] && sb_we_q[k] &&
                (sb_dst_q[k] == id_rs)) begin
                fwd_rs_sel  = SEL_W'(k + 1);
                fwd_rs_data = res_data[k*XLEN +: XLEN];
                w_rs_load0  = (k == 0) && sb_load_q[k];
            end
            if (id_use_rt && (id_rt != '0) && sb_valid_q[k] && sb_we_q[k] &&
                (sb_dst_q[k] == id_rt)) begin
                fwd_rt_sel  = SEL_W'(k + 1);
                fwd_rt_data = res_data[k*XLEN +: XLEN];
                w_rt_load0  = (k == 0) && sb_load_q[k];
            end
        end
    end

    // Load data only exists from MEM onwards, so a winning match on a load
    // still in EX must wait one cycle. A taken branch kills the decode
    // instruction anyway, so it suppresses the stall.
    assign flush = ex_branch_taken;
    assign stall = id_valid && !flush && (w_rs_load0 || w_rt_load0);

    // Stalled or flushed decode instructions enter EX as bubbles.
    assign w_entry0_valid_d = id_valid && !stall && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid_q <= '0;
            sb_we_q    <= '0;
            sb_load_q  <= '0;
            sb_dst_q   <= '0;
        end else begin
            sb_valid_q <= {sb_valid_q[DEPTH-2:0], w_entry0_valid_d};
            sb_we_q    <= {sb_we_q[DEPTH-2:0], id_we && w_entry0_valid_d};
            sb_load_q  <= {sb_load_q[DEPTH-2:0], id_is_load && w_entry0_valid_d};
            sb_dst_q   <= {sb_dst_q[DEPTH-2:0], id_dst};
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_unit
// Description : Self-checking bench for pipe_hazard_unit. A DEPTH=3 instance
//               runs a table of decode instructions with hand-computed
//               forwarding/stall/flush results; hand-written sequences cover
//               asynchronous reset and a DEPTH=5 instance ageing a producer
//               through every stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=3 instance stimulus
    logic        id_valid, id_use_rs, id_use_rt, id_we, id_is_load, br;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic [31:0] rf_rs, rf_rt;
    logic [95:0] res3;
    logic [31:0] rs_data, rt_data;
    logic [2:0]  rs_sel, rt_sel;
    logic        stall, flush;

    // DEPTH=5 instance stimulus
    logic         d5_valid, d5_use_rs, d5_we;
    logic [4:0]   d5_rs, d5_dst;
    logic [159:0] res5;
    logic [31:0]  d5_rs_data, d5_rt_data;
    logic [2:0]   d5_rs_sel, d5_rt_sel;
    logic         d5_stall, d5_flush;

`ifdef HAZARD_PERF_EN
    logic [31:0] sc3, fc3, sc5, fc5;
`endif

    pipe_hazard_unit #(.XLEN(32), .REG_AW(5), .DEPTH(3), .SEL_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_we(id_we),
        .id_is_load(id_is_load), .ex_branch_taken(br), .rf_rs_data(rf_rs),
        .rf_rt_data(rf_rt), .res_data(res3), .fwd_rs_data(rs_data), .fwd_rt_data(rt_data),
        .fwd_rs_sel(rs_sel), .fwd_rt_sel(rt_sel), .stall(stall), .flush(flush)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
    );

    pipe_hazard_unit #(.XLEN(32), .REG_AW(5), .DEPTH(5), .SEL_W(3)) u_dut5 (
        .clk(clk), .rst(rst), .id_valid(d5_valid), .id_rs(d5_rs), .id_rt(5'd0),
        .id_use_rs(d5_use_rs), .id_use_rt(1'b0), .id_dst(d5_dst), .id_we(d5_we),
        .id_is_load(1'b0), .ex_branch_taken(1'b0), .rf_rs_data(rf_rs),
        .rf_rt_data(rf_rt), .res_data(res5), .fwd_rs_data(d5_rs_data),
        .fwd_rt_data(d5_rt_data), .fwd_rs_sel(d5_rs_sel), .fwd_rt_sel(d5_rt_sel),
        .stall(d5_stall), .flush(d5_flush)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(sc5), .flush_cnt(fc5)
`endif
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       we;
        logic       ld;
        logic       br;
        logic [2:0] ers;
        logic [2:0] ert;
        logic       est;
        logic       efl;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp3(input logic [2:0] sel, input logic [31:0] rf);
        case (sel)
            3'd0:    exp3 = rf;
            3'd1:    exp3 = 32'h0000_00AA;
            3'd2:    exp3 = 32'h1234_5678;
            3'd3:    exp3 = 32'hCCCC_0002;
            default: exp3 = 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic vec_t mk(input logic v, input int rs, input int rt, input logic urs,
                                input logic urt, input int dst, input logic we, input logic ld,
                                input logic b, input int ers, input int ert, input logic est,
                                input logic efl);
        vec_t t;
        t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt; t.dst = 5'(dst);
        t.we = we; t.ld = ld; t.br = b; t.ers = 3'(ers); t.ert = 3'(ert); t.est = est;
        t.efl = efl;
        return t;
    endfunction

    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input int dst, input logic we, input logic ld,
                         input logic b);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_dst = 5'(dst); id_we = we; id_is_load = ld; br = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rf_rs = 32'h1111_1111;
        rf_rt = 32'h2222_2222;
        res3  = {32'hCCCC_0002, 32'h1234_5678, 32'h0000_00AA};
        res5  = {32'h5000_0004, 32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000};
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        d5_valid = 0; d5_use_rs = 0; d5_we = 0; d5_rs = '0; d5_dst = '0;

        // v  rs  rt urs urt dst we ld br | ers ert stall flush
        tbl[0]  = mk(1,  1,  2, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0); // add r3
        tbl[1]  = mk(1,  3,  2, 1, 1,  4, 1, 0, 0,  1, 0, 0, 0); // EX forward
        tbl[2]  = mk(1,  1,  5, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0); // lw r5
        tbl[3]  = mk(1,  5,  1, 1, 1,  6, 1, 0, 0,  1, 0, 1, 0); // load-use stall
        tbl[4]  = mk(1,  5,  1, 1, 1,  6, 1, 0, 0,  2, 0, 0, 0); // load now in MEM
        tbl[5]  = mk(1,  6,  5, 1, 1,  0, 1, 0, 0,  1, 3, 0, 0); // WB forward, writes r0
        tbl[6]  = mk(1,  0,  0, 1, 1,  7, 1, 0, 0,  0, 0, 0, 0); // reads r0
        tbl[7]  = mk(1,  1,  2, 1, 1,  8, 1, 0, 0,  0, 0, 0, 0);
        tbl[8]  = mk(1,  1,  2, 1, 1,  7, 1, 0, 0,  0, 0, 0, 0); // second r7 writer
        tbl[9]  = mk(1,  7,  8, 1, 0,  9, 1, 1, 0,  1, 0, 0, 0); // youngest r7; rt unused
        tbl[10] = mk(1,  9,  7, 1, 1, 12, 1, 0, 1,  1, 2, 0, 1); // load-use + flush
        tbl[11] = mk(1, 12,  9, 1, 1, 11, 1, 0, 0,  0, 2, 0, 0); // flushed r12 absent
        tbl[12] = mk(0, 11,  9, 1, 1, 13, 1, 0, 0,  1, 3, 0, 0); // invalid decode
        tbl[13] = mk(1, 13, 11, 1, 1, 14, 0, 0, 0,  0, 2, 0, 0); // r13 never entered
        tbl[14] = mk(1, 14, 11, 1, 1,  0, 0, 0, 0,  0, 3, 0, 0); // we=0 producer
        tbl[15] = mk(1,  1,  0, 1, 0, 15, 1, 1, 0,  0, 0, 0, 0); // lw r15
        tbl[16] = mk(1,  2, 15, 1, 1, 16, 1, 0, 0,  0, 1, 1, 0); // load-use on rt
        tbl[17] = mk(1,  2, 15, 1, 1, 16, 1, 0, 0,  0, 2, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rs_sel", 32'(rs_sel), 32'd0);
        chk("reset rt_sel", 32'(rt_sel), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset flush", 32'(flush), 32'd0);
        chk("reset rs_data", rs_data, rf_rs);
        chk("reset rt_data", rt_data, rf_rt);
        rst = 1'b0;

        // Table-driven program on the DEPTH=3 instance
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].v, 32'(tbl[i].rs), 32'(tbl[i].rt), tbl[i].urs, tbl[i].urt,
                  32'(tbl[i].dst), tbl[i].we, tbl[i].ld, tbl[i].br);
            #3;
            chk($sformatf("v%0d rs_sel", i), 32'(rs_sel), 32'(tbl[i].ers));
            chk($sformatf("v%0d rt_sel", i), 32'(rt_sel), 32'(tbl[i].ert));
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].est));
            chk($sformatf("v%0d flush", i), 32'(flush), 32'(tbl[i].efl));
            chk($sformatf("v%0d rs_data", i), rs_data, exp3(tbl[i].ers, rf_rs));
            chk($sformatf("v%0d rt_data", i), rt_data, exp3(tbl[i].ert, rf_rt));
            @(posedge clk);
            #1;
        end

        // Mid-cycle asynchronous reset with a load-use pending
        drive(1, 1, 2, 1, 1, 3, 1, 0, 0);  // add r3
        @(posedge clk); #1;
        drive(1, 1, 5, 1, 0, 5, 1, 1, 0);  // lw r5
        @(posedge clk); #1;
        drive(1, 5, 3, 1, 1, 6, 1, 0, 0);  // add r6,r5,r3
        #2;
        chk("pre-rst stall", 32'(stall), 32'd1);
        chk("pre-rst rt_sel", 32'(rt_sel), 32'd2);
        rst = 1'b1;
        #1;
        chk("async rst stall", 32'(stall), 32'd0);
        chk("async rst rs_sel", 32'(rs_sel), 32'd0);
        chk("async rst rt_sel", 32'(rt_sel), 32'd0);
        chk("async rst rs_data", rs_data, rf_rs);
        @(posedge clk);
        #4;
        rst = 1'b0;
        drive(1, 3, 2, 1, 1, 4, 1, 0, 0);  // add r4,r3,r2
        #1;
        chk("post-rst rs_sel", 32'(rs_sel), 32'd0);
        chk("post-rst rs_data", rs_data, rf_rs);
        chk("post-rst stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // DEPTH=5: producer of r9 ages through all five stages
        d5_valid = 1; d5_we = 1; d5_dst = 5'd9; d5_rs = 5'd0; d5_use_rs = 0;
        @(posedge clk); #1;
        d5_valid = 0; d5_we = 0; d5_dst = 5'd0; d5_rs = 5'd9; d5_use_rs = 1;
        for (int c = 1; c <= 6; c++) begin
            #3;
            chk($sformatf("d5 c%0d rs_sel", c), 32'(d5_rs_sel), (c <= 5) ? 32'(c) : 32'd0);
            chk($sformatf("d5 c%0d rs_data", c), d5_rs_data,
                (c <= 5) ? 32'h5000_0000 + 32'(c - 1) : rf_rs);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
